// File: rtl/mem_stage.sv
// Memory stage: one-outstanding data-memory access with alignment checking,
// byte-lane steering for stores and lane extraction/extension for loads.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_load,
    input  logic                   in_store,
    input  logic [1:0]             in_size,
    input  logic                   in_signed,
    input  logic [DATA_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_wdata,
    input  logic [DATA_W-1:0]      in_alu_result,
    input  logic [RA_W-1:0]        in_rd_addr,
    output logic                   stall_out,
    output logic                   misalign_err,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [DATA_W-1:0]      dmem_addr,
    output logic [3:0]             dmem_be,
    output logic [DATA_W-1:0]      dmem_wdata,
    input  logic                   dmem_ack,
    input  logic [DATA_W-1:0]      dmem_rdata,
    output logic [RA_W+DATA_W-1:0] wb_params_out  // {rd_addr, rd_data}
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, next_state;
    logic [1:0]        lat_size, lat_off;
    logic              lat_signed, lat_store;
    logic [RA_W-1:0]   lat_rd;
    logic [DATA_W-1:0] rdata_q;

    logic              is_mem, misaligned, accept;
    logic [3:0]        be_calc;
    logic [DATA_W-1:0] wdata_calc, shifted, load_data;

    assign is_mem     = in_load | in_store;
    assign misaligned = (in_size == 2'b01 && in_addr[0]) ||
                        (in_size == 2'b10 && in_addr[1:0] != 2'b00) ||
                        (in_size == 2'b11);
    assign accept     = (state == IDLE) && in_valid && is_mem && !misaligned;

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = in_wdata;
        case (in_size)
            2'b00: begin
                be_calc    = 4'b0001 << in_addr[1:0];
                wdata_calc = {(DATA_W/8){in_wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = in_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {(DATA_W/16){in_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Loads read the whole word; pick the addressed lane back out here.
    assign shifted = rdata_q >> {lat_off, 3'b000};
    always_comb begin
        case (lat_size)
            2'b00:   load_data = {{(DATA_W-8){lat_signed & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{(DATA_W-16){lat_signed & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        next_state    = state;
        stall_out     = 1'b0;
        misalign_err  = 1'b0;
        wb_params_out = '0;
        case (state)
            IDLE: begin
                if (in_valid && !is_mem)
                    wb_params_out = {in_rd_addr, in_alu_result};
                else if (in_valid && misaligned)
                    misalign_err = 1'b1;
                else if (accept) begin
                    stall_out  = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                stall_out = 1'b1;
                if (dmem_ack) next_state = DONE;
            end
            DONE: begin
                if (!lat_store) wb_params_out = {lat_rd, load_data};
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Combinational outputs must also drop the instant reset asserts.
        if (!rst_n) begin
            stall_out     = 1'b0;
            misalign_err  = 1'b0;
            wb_params_out = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            lat_size   <= '0;
            lat_off    <= '0;
            lat_signed <= 1'b0;
            lat_store  <= 1'b0;
            lat_rd     <= '0;
            rdata_q    <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                dmem_req   <= 1'b1;
                dmem_we    <= in_store;
                dmem_addr  <= {in_addr[DATA_W-1:2], 2'b00};
                dmem_be    <= be_calc;
                dmem_wdata <= wdata_calc;
                lat_size   <= in_size;
                lat_off    <= in_addr[1:0];
                lat_signed <= in_signed;
                lat_store  <= in_store;
                lat_rd     <= in_rd_addr;
            end else if (state == BUSY && dmem_ack) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
                rdata_q  <= dmem_rdata;
            end
        end
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data/address width in bits.
REQ-002 SHALL have parameter RA_W, default 4, register-address width; must match wb_params_t.rd_addr.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  upstream presents an instruction this cycle.
REQ-006 SHALL have ports in_load, in_store  in  1 each  op class; both 0 = non-memory op.
REQ-007 SHALL have port in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
REQ-008 SHALL have port in_signed  in  1  sign-extend load result when 1.
REQ-009 SHALL have ports in_addr, in_wdata, in_alu_result  in  DATA_W each  effective address, store data, ALU result.
REQ-010 SHALL have port in_rd_addr  in  RA_W  destination register; 0 = no writeback.
REQ-011 SHALL have port stall_out  out  1  upstream must hold its inputs.
REQ-012 SHALL have port misalign_err  out  1  one-cycle misaligned-access pulse.
REQ-013 SHALL have ports dmem_req, dmem_we  out  1, dmem_addr  out  DATA_W (bits [1:0] = 0), dmem_be  out  4, dmem_wdata  out  DATA_W.
REQ-014 SHALL have ports dmem_ack  in  1, dmem_rdata  in  DATA_W.
REQ-015 SHALL have port wb_params_out  out  wb_params_t  {rd_addr, rd_data} to the MEM/WB register.

Function
REQ-016 SHALL implement FSM IDLE, BUSY, DONE; reset state IDLE.
REQ-017 In IDLE with in_valid and no memory op: wb_params_out = {in_rd_addr, in_alu_result} combinationally, stall_out 0, zero latency.
REQ-018 In IDLE with in_valid=0: wb_params_out = {0, 0}.
REQ-019 Misaligned = half with addr[0]=1, word with addr[1:0]!=0, or size 11; on misaligned memory op in IDLE: misalign_err 1 that cycle, no bus access, wb_params_out {0,0}, stall_out 0, stay IDLE.
REQ-020 Aligned memory op in IDLE: stall_out 1 same cycle; latch addr, size, signed, rd_addr, we, be, wdata; next state BUSY; wb_params_out {0,0}.
REQ-021 dmem_* outputs SHALL be registered; dmem_req 1 exactly while in BUSY, address/be/wdata/we stable throughout.
REQ-022 In BUSY: stall_out 1, wb_params_out {0,0}; dmem_ack=1 captures dmem_rdata, next state DONE; dmem_ack=0 stays BUSY indefinitely.
REQ-023 In DONE: stall_out 0; load -> {latched rd_addr, extracted data}; store -> {0,0}; next state IDLE; inputs ignored this cycle.
REQ-024 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011 (addr[1]=0) or 4'b1100; word 4'b1111.
REQ-025 Store data SHALL be replicated into all lanes (byte x4, half x2, word as-is).
REQ-026 Load extraction: shift rdata right by 8*addr[1:0], keep 8/16/32 bits, sign- or zero-extend to DATA_W per in_signed.
REQ-027 Load with rd_addr 0 SHALL still perform the bus access; writeback rd_addr stays 0.
REQ-028 dmem_ack outside BUSY SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, dmem_req/dmem_we 0, dmem_addr/be/wdata 0, all latched fields 0, stall_out 0, misalign_err 0, wb_params_out {0,0}.
REQ-030 Reset during BUSY SHALL abandon the transaction; a late ack after release is ignored per REQ-028.

Verification
REQ-031 ALU op in_rd_addr=3, in_alu_result=0x1234 -> same cycle wb_params_out {3,0x1234}, stall_out 0, dmem_req 0.
REQ-032 Byte signed load addr 0x1003, ack after 3 BUSY cycles, rdata 0x80FFFFFF, rd 5 -> dmem_addr 0x1000, be 0001<<3=1000, stall 5 cycles total (IDLE + 3 BUSY + ack cycle), DONE output {5,0xFFFFFF80}.
REQ-033 Half store addr 0x2002 wdata 0xABCD, ack first BUSY cycle -> be 1100, dmem_wdata 0xABCDABCD, dmem_we 1, DONE output {0,0}.
REQ-034 Word load addr 0x3001 -> misalign_err pulse 1 cycle, dmem_req never asserted, stall_out 0.
REQ-035 rst_n low mid-BUSY, ack asserted after release -> dmem_req 0 immediately, FSM IDLE, no writeback emitted.
